id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised next-generation decode stage: decodes the logic/shift/nop instruction set plus ADDIU, resolves operands with EX/MEM forwarding, detects load-use hazards, and contains the ID/EX pipeline register.
- Sits between if_id and ex; drives the regfile read ports combinationally and ex from registered outputs.
- Adds load-use interlock, flush, downstream-stall hold, $0 forwarding suppression and a saturating stall counter.

Parameters:
- DATA_W, 32, operand/data width; must be >= 32.
- REG_ADDR_W, 5, register address width.
- ALUOP_W, 8, aluop field width.
- ALUSEL_W, 3, alusel field width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pc_i  in  32  PC of the instruction in decode.
- inst_i  in  32  instruction in decode.
- inst_valid_i  in  1  inst_i is a real instruction, not a bubble.
- stall_i  in  1  downstream stall; hold the ID/EX register.
- flush_i  in  1  discard the decode-stage instruction.
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data.
- ex_wreg_i  in  1  EX-stage write enable.
- ex_wd_i  in  REG_ADDR_W  EX-stage write address.
- ex_wdata_i  in  DATA_W  EX-stage result.
- ex_is_load_i  in  1  EX-stage instruction is a load.
- mem_wreg_i  in  1  MEM-stage write enable.
- mem_wd_i  in  REG_ADDR_W  MEM-stage write address.
- mem_wdata_i  in  DATA_W  MEM-stage result.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o, reg2_addr_o  out  REG_ADDR_W  regfile read addresses (combinational).
- stallreq_o  out  1  load-use stall request to the control unit (combinational).
- ex_aluop_o  out  ALUOP_W  registered aluop.
- ex_alusel_o  out  ALUSEL_W  registered alusel.
- ex_reg1_o, ex_reg2_o  out  DATA_W  registered operands.
- ex_wd_o  out  REG_ADDR_W  registered destination address.
- ex_wreg_o  out  1  registered write enable.
- ex_valid_o  out  1  registered valid bit.
- ex_pc_o  out  32  registered PC.
- stall_cnt_o  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset:
  - rst is asynchronous, active-low.
  - While rst=0, all ex_* outputs are 0, ex_aluop_o=NOP, ex_alusel_o=RES_NOP, stall_cnt_o=0, FSM=RUN.
  - Combinational outputs are 0 while rst=0.
- Decode set: OR, AND, XOR, NOR, SLLV, SRLV, SRAV, SLL, SRL, SRA, ORI, ANDI, XORI, LUI, ADDIU, SYNC, PREF.
- Immediate forms:
  - ORI/ANDI/XORI zero-extend imm16.
  - LUI uses {imm16,16'h0}.
  - ADDIU sign-extends imm16 to DATA_W, selecting RES_ARITH/ADDU_OP.
  - Shifts by sa place inst[10:6] in the low bits of operand 1, zero elsewhere.
- SYNC and PREF: wreg=0, no regfile read, valid nop.
- Unrecognised opcode: treated as nop (wreg=0), ex_valid_o still follows inst_valid_i.
- Operand priority, per port:
  - If the read address is 0, the operand is 0 regardless of forwarding.
  - Otherwise: EX match, then MEM match, then regfile, then immediate when the read is disabled.
- Load-use hazard: ex_is_load_i & ex_wreg_i & ex_wd_i!=0 & (read1 & addr1==ex_wd_i | read2 & addr2==ex_wd_i).
- FSM:
  - RUN:
    - hazard & !stall_i → stallreq_o=1, load a bubble into ID/EX (ex_valid_o=0, ex_wreg_o=0, NOP), stall_cnt_o+=1 (saturates at all-ones), go LU_STALL.
    - Otherwise load the decoded instruction.
  - LU_STALL:
    - The same instruction is held upstream; the load has moved to MEM, so the MEM path forwards.
    - stallreq_o=0, load the decoded instruction, return to RUN.
- Priority, highest first: rst, stall_i, flush_i, load-use.
  - stall_i=1: ID/EX holds, FSM holds, stallreq_o is still evaluated.
  - flush_i=1 (without stall_i): load a bubble, FSM→RUN, counter unchanged.
- Latency: one cycle from inst_i to ex_* outputs; load-use adds exactly one bubble.

Optional Feature:
- Macro: ID_INVALID_TRAP_EN.
- When defined:
  - Extra output ex_excp_invalid_o (1), registered with the same hold/flush/bubble rules.
  - It is 1 when inst_valid_i=1 and the opcode is unrecognised; ex_wreg_o=0 for that instruction.
  - Reset value 0.
- When undefined: the port is absent and unrecognised opcodes are silent nops.

Decomposition:
- Shared package id_pkg holds:
  - Opcode and funct constants (EXE_OR, EXE_ADDIU, …).
  - aluop/alusel codes including ADDU_OP and RES_ARITH.
  - The FSM state typedef {RUN, LU_STALL}.
- One sub-module, id_fwd_mux: the per-port operand select (addr0 check, EX/MEM/regfile/imm), instantiated twice.
- Decode, FSM, counter and the ID/EX register stay in id_stage_pipe.

Test Plan:
- Reset with rst=0 mid-stream, inst ORI active → all ex_* outputs 0 immediately (asynchronous); after release, ORI $1,$0,0x1100 → ex_reg1_o=0, ex_reg2_o=0x00001100, ex_wd_o=1 one cycle later.
- Forwarding: OR $3,$1,$2 with ex_wd_i=1/ex_wdata_i=0xA and mem_wd_i=2/mem_wdata_i=0xB → operands 0xA, 0xB. With ex_wd_i=0, ex_wreg_i=1 and reading $0 → operand 0.
- Load-use: ex_is_load_i=1, ex_wd_i=4, decode AND $5,$4,$6 → stallreq_o=1, next cycle ex_valid_o=0 and stall_cnt_o=1; the following cycle the MEM-forwarded value 0x55 appears on ex_reg1_o.
- ADDIU $2,$1,0xFFF0 with reg1=0x10 → ex_reg2_o=0xFFFFFFF0, ex_alusel_o=RES_ARITH.
- stall_i=1 for 3 cycles with flush_i=1 → ex_* outputs unchanged; then stall_i=0, flush_i=1 → bubble loaded, counter unchanged.
- Counter saturation with CNT_W=2: 5 load-use events → stall_cnt_o=3. With ID_INVALID_TRAP_EN, opcode 6'h3F → ex_excp_invalid_o=1, ex_wreg_o=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcode/funct encodings, aluop and
// alusel codes, the decode-FSM state type and the SPECIAL-funct aluop map.
package id_pkg;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_PREF    = 6'b110011;

  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRA  = 6'b000011;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;

  localparam logic [7:0] NOP_OP  = 8'b00000000;
  localparam logic [7:0] AND_OP  = 8'b00100100;
  localparam logic [7:0] OR_OP   = 8'b00100101;
  localparam logic [7:0] XOR_OP  = 8'b00100110;
  localparam logic [7:0] NOR_OP  = 8'b00100111;
  localparam logic [7:0] SLL_OP  = 8'b01111100;
  localparam logic [7:0] SRL_OP  = 8'b00000010;
  localparam logic [7:0] SRA_OP  = 8'b00000011;
  localparam logic [7:0] SLLV_OP = 8'b00000100;
  localparam logic [7:0] SRLV_OP = 8'b00000110;
  localparam logic [7:0] SRAV_OP = 8'b00000111;
  localparam logic [7:0] ADDU_OP = 8'b00100001;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;

  typedef logic [0:0] id_state_t;
  localparam id_state_t RUN      = 1'b0;
  localparam id_state_t LU_STALL = 1'b1;

  function automatic logic [7:0] special_aluop(input logic [5:0] funct);
    case (funct)
      EXE_AND:  return AND_OP;
      EXE_OR:   return OR_OP;
      EXE_XOR:  return XOR_OP;
      EXE_NOR:  return NOR_OP;
      EXE_SLL:  return SLL_OP;
      EXE_SRL:  return SRL_OP;
      EXE_SRA:  return SRA_OP;
      EXE_SLLV: return SLLV_OP;
      EXE_SRLV: return SRLV_OP;
      EXE_SRAV: return SRAV_OP;
      default:  return NOP_OP;
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-port operand select: $0 forces zero, then EX forward, MEM forward,
// regfile data, and the decoded immediate when the port does not read.
module id_fwd_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  rd_en,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic [DATA_W-1:0]     imm,
  input  logic                  ex_wreg,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  mem_wreg,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     operand
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves operand unassigned (no latch).
    operand = imm;
    if (rd_en) begin
      if (rd_addr == '0)
        operand = '0;
      else if (ex_wreg && (ex_wd == rd_addr))
        operand = ex_wdata;
      else if (mem_wreg && (mem_wd == rd_addr))
        operand = mem_wdata;
      else
        operand = rf_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with EX/MEM forwarding, load-use interlock and the ID/EX register.
// Optional: define ID_INVALID_TRAP_EN to add ex_excp_invalid_o for unrecognised opcodes.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           inst_i,
  input  logic                  inst_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  output logic                  stallreq_o,
  output logic [ALUOP_W-1:0]    ex_aluop_o,
  output logic [ALUSEL_W-1:0]   ex_alusel_o,
  output logic [DATA_W-1:0]     ex_reg1_o,
  output logic [DATA_W-1:0]     ex_reg2_o,
  output logic [REG_ADDR_W-1:0] ex_wd_o,
  output logic                  ex_wreg_o,
  output logic                  ex_valid_o,
  output logic [31:0]           ex_pc_o,
  output logic [CNT_W-1:0]      stall_cnt_o
`ifdef ID_INVALID_TRAP_EN
  ,
  output logic                  ex_excp_invalid_o
`endif
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic                  dec_rd1, dec_rd2, dec_wreg, dec_known;
  logic [REG_ADDR_W-1:0] dec_a1, dec_a2, dec_wd;
  logic [DATA_W-1:0]     dec_imm;
  logic [ALUOP_W-1:0]    dec_aluop;
  logic [ALUSEL_W-1:0]   dec_alusel;

  always_comb begin
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_a1     = REG_ADDR_W'(rs);
    dec_a2     = REG_ADDR_W'(rt);
    dec_wd     = '0;
    dec_wreg   = 1'b0;
    dec_known  = 1'b0;
    dec_imm    = '0;
    dec_aluop  = ALUOP_W'(NOP_OP);
    dec_alusel = ALUSEL_W'(RES_NOP);
    case (op)
      EXE_SPECIAL: begin
        case (funct)
          EXE_OR, EXE_AND, EXE_XOR, EXE_NOR, EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
            dec_rd1    = 1'b1;
            dec_rd2    = 1'b1;
            dec_wd     = REG_ADDR_W'(rd);
            dec_wreg   = 1'b1;
            dec_known  = 1'b1;
            dec_aluop  = ALUOP_W'(special_aluop(funct));
            dec_alusel = (funct[5] ? ALUSEL_W'(RES_LOGIC) : ALUSEL_W'(RES_SHIFT));
          end
          // Shift-by-sa: operand 1 carries the shift amount instead of rs.
          EXE_SLL, EXE_SRL, EXE_SRA: begin
            dec_rd2    = 1'b1;
            dec_imm    = DATA_W'(sa);
            dec_wd     = REG_ADDR_W'(rd);
            dec_wreg   = 1'b1;
            dec_known  = 1'b1;
            dec_aluop  = ALUOP_W'(special_aluop(funct));
            dec_alusel = ALUSEL_W'(RES_SHIFT);
          end
          EXE_SYNC: dec_known = 1'b1;
          default: ;
        endcase
      end
      EXE_ORI, EXE_ANDI, EXE_XORI: begin
        dec_rd1    = 1'b1;
        dec_imm    = DATA_W'(imm16);
        dec_wd     = REG_ADDR_W'(rt);
        dec_wreg   = 1'b1;
        dec_known  = 1'b1;
        dec_alusel = ALUSEL_W'(RES_LOGIC);
        dec_aluop  = (op == EXE_ORI)  ? ALUOP_W'(OR_OP)  :
                     (op == EXE_ANDI) ? ALUOP_W'(AND_OP) : ALUOP_W'(XOR_OP);
      end
      EXE_LUI: begin
        dec_rd1    = 1'b1;
        dec_imm    = DATA_W'({imm16, 16'h0000});
        dec_wd     = REG_ADDR_W'(rt);
        dec_wreg   = 1'b1;
        dec_known  = 1'b1;
        dec_aluop  = ALUOP_W'(OR_OP);
        dec_alusel = ALUSEL_W'(RES_LOGIC);
      end
      EXE_ADDIU: begin
        dec_rd1    = 1'b1;
        dec_imm    = DATA_W'($signed(imm16));
        dec_wd     = REG_ADDR_W'(rt);
        dec_wreg   = 1'b1;
        dec_known  = 1'b1;
        dec_aluop  = ALUOP_W'(ADDU_OP);
        dec_alusel = ALUSEL_W'(RES_ARITH);
      end
      EXE_PREF: dec_known = 1'b1;
      default: ;
    endcase
  end

  logic [DATA_W-1:0] op1, op2;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
    .rd_en(dec_rd1), .rd_addr(dec_a1), .rf_data(reg1_data_i), .imm(dec_imm),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .operand(op1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
    .rd_en(dec_rd2), .rd_addr(dec_a2), .rf_data(reg2_data_i), .imm(dec_imm),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .operand(op2)
  );

  id_state_t state_q;
  logic      hazard, lu_hit, take_bubble, lu_enter;

  assign hazard = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                  ((dec_rd1 && (dec_a1 == ex_wd_i)) || (dec_rd2 && (dec_a2 == ex_wd_i)));
  // Only the first decode of a load-use pair stalls; the retry forwards from MEM.
  assign lu_hit      = (state_q == RUN) && hazard;
  assign lu_enter    = lu_hit && !flush_i;
  assign take_bubble = flush_i || lu_hit;

  assign reg1_read_o = rst && dec_rd1;
  assign reg2_read_o = rst && dec_rd2;
  assign reg1_addr_o = rst ? dec_a1 : '0;
  assign reg2_addr_o = rst ? dec_a2 : '0;
  assign stallreq_o  = rst && lu_hit && (stall_i || !flush_i);

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      ex_aluop_o        <= ALUOP_W'(NOP_OP);
      ex_alusel_o       <= ALUSEL_W'(RES_NOP);
      ex_reg1_o         <= '0;
      ex_reg2_o         <= '0;
      ex_wd_o           <= '0;
      ex_wreg_o         <= 1'b0;
      ex_valid_o        <= 1'b0;
      ex_pc_o           <= '0;
`ifdef ID_INVALID_TRAP_EN
      ex_excp_invalid_o <= 1'b0;
`endif
      state_q           <= RUN;
      stall_cnt_o       <= '0;
    end else if (!stall_i) begin
      if (take_bubble) begin
        ex_aluop_o        <= ALUOP_W'(NOP_OP);
        ex_alusel_o       <= ALUSEL_W'(RES_NOP);
        ex_reg1_o         <= '0;
        ex_reg2_o         <= '0;
        ex_wd_o           <= '0;
        ex_wreg_o         <= 1'b0;
        ex_valid_o        <= 1'b0;
        ex_pc_o           <= '0;
`ifdef ID_INVALID_TRAP_EN
        ex_excp_invalid_o <= 1'b0;
`endif
      end else begin
        ex_aluop_o        <= dec_aluop;
        ex_alusel_o       <= dec_alusel;
        ex_reg1_o         <= op1;
        ex_reg2_o         <= op2;
        ex_wd_o           <= dec_wd;
        ex_wreg_o         <= dec_wreg && dec_known && inst_valid_i;
        ex_valid_o        <= inst_valid_i;
        ex_pc_o           <= pc_i;
`ifdef ID_INVALID_TRAP_EN
        ex_excp_invalid_o <= inst_valid_i && !dec_known;
`endif
      end
      state_q <= lu_enter ? LU_STALL : RUN;
      if (lu_enter && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized traffic
// checked every cycle against an instruction-level model. Honors ID_INVALID_TRAP_EN.
module tb_id_stage_pipe;

  localparam int K_OR = 0, K_AND = 1, K_XOR = 2, K_NOR = 3, K_SLLV = 4, K_SRLV = 5,
                 K_SRAV = 6, K_SLL = 7, K_SRL = 8, K_SRA = 9, K_ORI = 10, K_ANDI = 11,
                 K_XORI = 12, K_LUI = 13, K_ADDIU = 14, K_SYNC = 15, K_PREF = 16, K_INV = 17;

  typedef struct packed {
    logic        r1, r2;
    logic [4:0]  a1, a2;
    logic [31:0] imm;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic        known;
  } dec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0;
  logic        inst_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] reg1_data_i = '0, reg2_data_i = '0;
  logic        ex_wreg_i = 1'b0, ex_is_load_i = 1'b0, mem_wreg_i = 1'b0;
  logic [4:0]  ex_wd_i = '0, mem_wd_i = '0;
  logic [31:0] ex_wdata_i = '0, mem_wdata_i = '0;

  logic        reg1_read_o, reg2_read_o, stallreq_o, ex_wreg_o, ex_valid_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wd_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;
  logic [15:0] stall_cnt_o;
  logic        excp_o;

  logic        s_r1, s_r2, s_stallreq, s_wreg, s_valid;
  logic [4:0]  s_a1, s_a2, s_wd;
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1, s_reg2, s_pc;
  logic [1:0]  s_cnt;
  logic        s_excp;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o),
    .reg2_addr_o(reg2_addr_o), .stallreq_o(stallreq_o), .ex_aluop_o(ex_aluop_o),
    .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .stall_cnt_o(stall_cnt_o)
`ifdef ID_INVALID_TRAP_EN
    , .ex_excp_invalid_o(excp_o)
`endif
  );

  id_stage_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .reg1_read_o(s_r1), .reg2_read_o(s_r2), .reg1_addr_o(s_a1), .reg2_addr_o(s_a2),
    .stallreq_o(s_stallreq), .ex_aluop_o(s_aluop), .ex_alusel_o(s_alusel), .ex_reg1_o(s_reg1),
    .ex_reg2_o(s_reg2), .ex_wd_o(s_wd), .ex_wreg_o(s_wreg), .ex_valid_o(s_valid), .ex_pc_o(s_pc),
    .stall_cnt_o(s_cnt)
`ifdef ID_INVALID_TRAP_EN
    , .ex_excp_invalid_o(s_excp)
`endif
  );

`ifndef ID_INVALID_TRAP_EN
  assign excp_o = 1'b0;
  assign s_excp = 1'b0;
`endif

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decode of the instruction currently on inst_i, built with the instruction.
  dec_t cur = '0;

  task automatic drive_inst(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
    dec_t d;
    logic [5:0] op, fn;
    d = '0; op = 6'h00; fn = 6'h00;
    case (kind)
      K_OR:    begin fn = 6'h25; d.aluop = 8'h25; d.alusel = 3'd1; end
      K_AND:   begin fn = 6'h24; d.aluop = 8'h24; d.alusel = 3'd1; end
      K_XOR:   begin fn = 6'h26; d.aluop = 8'h26; d.alusel = 3'd1; end
      K_NOR:   begin fn = 6'h27; d.aluop = 8'h27; d.alusel = 3'd1; end
      K_SLLV:  begin fn = 6'h04; d.aluop = 8'h04; d.alusel = 3'd2; end
      K_SRLV:  begin fn = 6'h06; d.aluop = 8'h06; d.alusel = 3'd2; end
      K_SRAV:  begin fn = 6'h07; d.aluop = 8'h07; d.alusel = 3'd2; end
      K_SLL:   begin fn = 6'h00; d.aluop = 8'h7C; d.alusel = 3'd2; end
      K_SRL:   begin fn = 6'h02; d.aluop = 8'h02; d.alusel = 3'd2; end
      K_SRA:   begin fn = 6'h03; d.aluop = 8'h03; d.alusel = 3'd2; end
      K_ORI:   begin op = 6'h0D; d.aluop = 8'h25; d.alusel = 3'd1; end
      K_ANDI:  begin op = 6'h0C; d.aluop = 8'h24; d.alusel = 3'd1; end
      K_XORI:  begin op = 6'h0E; d.aluop = 8'h26; d.alusel = 3'd1; end
      K_LUI:   begin op = 6'h0F; d.aluop = 8'h25; d.alusel = 3'd1; end
      K_ADDIU: begin op = 6'h09; d.aluop = 8'h21; d.alusel = 3'd4; end
      K_SYNC:  fn = 6'h0F;
      K_PREF:  op = 6'h33;
      default: op = 6'h3F;
    endcase
    if (kind <= K_SRAV) begin
      d.r1 = 1; d.r2 = 1; d.a1 = rs; d.a2 = rt; d.wd = rd; d.wreg = 1; d.known = 1;
      inst_i = {6'h00, rs, rt, rd, 5'd0, fn};
    end else if (kind <= K_SRA) begin
      d.r2 = 1; d.a2 = rt; d.imm = {27'd0, sa}; d.wd = rd; d.wreg = 1; d.known = 1;
      inst_i = {6'h00, 5'd0, rt, rd, sa, fn};
    end else if (kind <= K_XORI) begin
      d.r1 = 1; d.a1 = rs; d.imm = {16'd0, imm}; d.wd = rt; d.wreg = 1; d.known = 1;
      inst_i = {op, rs, rt, imm};
    end else if (kind == K_LUI) begin
      d.r1 = 1; d.a1 = 5'd0; d.imm = {imm, 16'd0}; d.wd = rt; d.wreg = 1; d.known = 1;
      inst_i = {op, 5'd0, rt, imm};
    end else if (kind == K_ADDIU) begin
      d.r1 = 1; d.a1 = rs; d.imm = {{16{imm[15]}}, imm}; d.wd = rt; d.wreg = 1; d.known = 1;
      inst_i = {op, rs, rt, imm};
    end else if (kind == K_SYNC) begin
      d.known = 1;
      inst_i = {26'd0, fn};
    end else begin
      d.known = (kind == K_PREF);
      inst_i = {op, rs, rt, imm};
    end
    cur  = d;
    pc_i = pc_i + 32'd4;
  endtask

  // Instruction-level model: what EX must see after each edge.
  logic [7:0]  m_aluop = '0;
  logic [2:0]  m_alusel = '0;
  logic [31:0] m_reg1 = '0, m_reg2 = '0, m_pc = '0;
  logic [4:0]  m_wd = '0;
  logic        m_wreg = 0, m_valid = 0, m_excp = 0, m_retry = 0;
  int          m_cnt = 0;

  function automatic logic [31:0] fwd(input logic rd_en, input logic [4:0] a,
                                      input logic [31:0] rf, input logic [31:0] imm);
    if (!rd_en) return imm;
    if (a == 5'd0) return 32'd0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf;
  endfunction

  function automatic logic load_use();
    return ex_is_load_i && ex_wreg_i && ex_wd_i != 5'd0 &&
           ((cur.r1 && cur.a1 == ex_wd_i) || (cur.r2 && cur.a2 == ex_wd_i));
  endfunction

  task automatic model_bubble();
    m_aluop = '0; m_alusel = '0; m_reg1 = '0; m_reg2 = '0; m_pc = '0;
    m_wd = '0; m_wreg = 0; m_valid = 0; m_excp = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_bubble();
      m_retry = 0;
      m_cnt   = 0;
    end else if (!stall_i) begin
      if (flush_i) begin
        model_bubble();
        m_retry = 0;
      end else if (!m_retry && load_use()) begin
        model_bubble();
        m_retry = 1;
        m_cnt++;
      end else begin
        m_aluop  = cur.aluop;
        m_alusel = cur.alusel;
        m_reg1   = fwd(cur.r1, cur.a1, reg1_data_i, cur.imm);
        m_reg2   = fwd(cur.r2, cur.a2, reg2_data_i, cur.imm);
        m_wd     = cur.wd;
        m_wreg   = cur.wreg && inst_valid_i;
        m_valid  = inst_valid_i;
        m_pc     = pc_i;
`ifdef ID_INVALID_TRAP_EN
        m_excp   = inst_valid_i && !cur.known;
`endif
        m_retry  = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("reg1_read", reg1_read_o, rst && cur.r1);
    check("reg2_read", reg2_read_o, rst && cur.r2);
    if (!rst) begin
      check("reg1_addr_rst", reg1_addr_o, 0);
      check("reg2_addr_rst", reg2_addr_o, 0);
    end else begin
      if (cur.r1) check("reg1_addr", reg1_addr_o, cur.a1);
      if (cur.r2) check("reg2_addr", reg2_addr_o, cur.a2);
    end
    check("stallreq", stallreq_o, rst && !m_retry && load_use() && (stall_i || !flush_i));
    check("ex_aluop", ex_aluop_o, m_aluop);
    check("ex_alusel", ex_alusel_o, m_alusel);
    check("ex_reg1", ex_reg1_o, m_reg1);
    check("ex_reg2", ex_reg2_o, m_reg2);
    check("ex_wd", ex_wd_o, m_wd);
    check("ex_wreg", ex_wreg_o, m_wreg);
    check("ex_valid", ex_valid_o, m_valid);
    check("ex_pc", ex_pc_o, m_pc);
    check("ex_excp", excp_o, m_excp);
    check("stall_cnt", stall_cnt_o, (m_cnt > 65535) ? 65535 : m_cnt);
    check("stall_cnt_w2", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  initial begin
    drive_inst(K_SYNC, 0, 0, 0, 0, 0);
    inst_valid_i = 1;
    tick(); tick();
    rst = 1;

    // Async reset mid-stream with ORI in flight.
    drive_inst(K_ORI, 5'd0, 5'd7, 5'd0, 5'd0, 16'h1234);
    tick();
    check("pre_rst_wd", ex_wd_o, 5'd7);
    check("pre_rst_reg2", ex_reg2_o, 32'h1234);
    #2 rst = 0;
    #1;
    check("async_rst_wd", ex_wd_o, 0);
    check("async_rst_reg2", ex_reg2_o, 0);
    check("async_rst_valid", ex_valid_o, 0);
    check("async_rst_read1", reg1_read_o, 0);
    tick();
    rst = 1;

    drive_inst(K_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1100);
    tick();
    check("ori_reg1", ex_reg1_o, 32'h0);
    check("ori_reg2", ex_reg2_o, 32'h0000_1100);
    check("ori_wd", ex_wd_o, 5'd1);

    // EX and MEM forwarding, then $0 suppression.
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hA;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'hB;
    reg1_data_i = 32'h111; reg2_data_i = 32'h222;
    drive_inst(K_OR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
    tick();
    check("fwd_ex", ex_reg1_o, 32'hA);
    check("fwd_mem", ex_reg2_o, 32'hB);
    ex_wd_i = 0; ex_wdata_i = 32'hDEAD;
    drive_inst(K_OR, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0);
    tick();
    check("fwd_zero", ex_reg1_o, 32'h0);

    // Load-use: one bubble, then MEM forwards the loaded value.
    clear_fwd();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 4; ex_wdata_i = 32'h99;
    drive_inst(K_AND, 5'd4, 5'd6, 5'd5, 5'd0, 16'h0);
    #2 check("lu_stallreq", stallreq_o, 1);
    tick();
    check("lu_bubble_valid", ex_valid_o, 0);
    check("lu_cnt", stall_cnt_o, 1);
    clear_fwd();
    mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h55;
    #2 check("lu_retry_stallreq", stallreq_o, 0);
    tick();
    check("lu_mem_fwd", ex_reg1_o, 32'h55);
    check("lu_retry_valid", ex_valid_o, 1);

    clear_fwd();
    reg1_data_i = 32'h10;
    drive_inst(K_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFF0);
    tick();
    check("addiu_reg2", ex_reg2_o, 32'hFFFF_FFF0);
    check("addiu_alusel", ex_alusel_o, 3'b100);
    check("addiu_reg1", ex_reg1_o, 32'h10);

    // stall_i outranks flush_i: hold for 3 cycles, then flush alone.
    stall_i = 1; flush_i = 1;
    drive_inst(K_XOR, 5'd3, 5'd4, 5'd9, 5'd0, 16'h0);
    repeat (3) begin
      tick();
      check("hold_reg2", ex_reg2_o, 32'hFFFF_FFF0);
      check("hold_wd", ex_wd_o, 5'd2);
      check("hold_valid", ex_valid_o, 1);
    end
    stall_i = 0;
    tick();
    check("flush_valid", ex_valid_o, 0);
    check("flush_aluop", ex_aluop_o, 0);
    check("flush_cnt", stall_cnt_o, 1);
    flush_i = 0;

    // Five more load-use events: wide counter 6, 2-bit counter saturates at 3.
    repeat (5) begin
      clear_fwd();
      ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 4;
      drive_inst(K_AND, 5'd4, 5'd6, 5'd5, 5'd0, 16'h0);
      tick();
      clear_fwd();
      tick();
    end
    check("sat_cnt16", stall_cnt_o, 6);
    check("sat_cnt2", s_cnt, 2'd3);

`ifdef ID_INVALID_TRAP_EN
    drive_inst(K_INV, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1);
    tick();
    check("trap_excp", excp_o, 1);
    check("trap_wreg", ex_wreg_o, 0);
`endif

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      drive_inst($urandom_range(0, 17), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom));
      pc_i         = $urandom;
      inst_valid_i = ($urandom_range(0, 9) != 0);
      stall_i      = ($urandom_range(0, 9) == 0);
      flush_i      = ($urandom_range(0, 11) == 0);
      reg1_data_i  = $urandom;
      reg2_data_i  = $urandom;
      ex_wreg_i    = $urandom_range(0, 1);
      ex_wd_i      = 5'($urandom_range(0, 7));
      ex_wdata_i   = $urandom;
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      mem_wreg_i   = $urandom_range(0, 1);
      mem_wd_i     = 5'($urandom_range(0, 7));
      mem_wdata_i  = $urandom;
      tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
